// File: rtl/ext_periph_obi_demux.sv
// Purpose : OBI 1-to-NPORTS address demux for external peripherals with
//           in-order response tracking (FIFO of granted port indices).
// Latency : zero added cycles on request and response paths (both combinational).
// Backpressure: m_gnt_o drops while the tracking FIFO is full, while the target
//           differs from the youngest outstanding port, or when the slave withholds gnt.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   m_*                  master side OBI (req/we/be/addr/wdata -> gnt/rvalid/rdata)
//   s_req_o              per-port request, only the decoded port and only when admissible
//   s_we_o/be_o/addr_o/wdata_o  per-port copies of the master request (zero while m_req_i low)
//   s_gnt_i/rvalid_i/rdata_i    per-port grant and response
//
// Optional feature: define EXT_PERIPH_DEMUX_ERR_RESP_EN to build an internal error
// responder that answers unmapped addresses with 32'hBADACCE5 one cycle after grant.
// Without it, unmapped addresses are routed to port 0.

package ext_periph_obi_demux_pkg;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

  localparam logic [31:0] EXT_PERIPHERAL_START_ADDRESS = 32'h2000_0000;
  localparam int unsigned EXT_PERIPH_NPORTS = 5;

  // Testharness map: five consecutive 4 KiB windows.
  localparam addr_map_rule_t [EXT_PERIPH_NPORTS-1:0] EXT_PERIPH_RULES = '{
    '{idx: 32'd4, start_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h4000,
                  end_addr:   EXT_PERIPHERAL_START_ADDRESS + 32'h5000},
    '{idx: 32'd3, start_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h3000,
                  end_addr:   EXT_PERIPHERAL_START_ADDRESS + 32'h4000},
    '{idx: 32'd2, start_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h2000,
                  end_addr:   EXT_PERIPHERAL_START_ADDRESS + 32'h3000},
    '{idx: 32'd1, start_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h1000,
                  end_addr:   EXT_PERIPHERAL_START_ADDRESS + 32'h2000},
    '{idx: 32'd0, start_addr: EXT_PERIPHERAL_START_ADDRESS + 32'h0000,
                  end_addr:   EXT_PERIPHERAL_START_ADDRESS + 32'h1000}
  };

endpackage

module ext_periph_obi_demux
  import ext_periph_obi_demux_pkg::*;
#(
  parameter int unsigned NPORTS          = 5,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter addr_map_rule_t [NPORTS-1:0] ADDR_RULES = EXT_PERIPH_RULES
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     m_req_i,
  input  logic                     m_we_i,
  input  logic [3:0]               m_be_i,
  input  logic [31:0]              m_addr_i,
  input  logic [31:0]              m_wdata_i,
  output logic                     m_gnt_o,
  output logic                     m_rvalid_o,
  output logic [31:0]              m_rdata_o,
  output logic [NPORTS-1:0]        s_req_o,
  output logic [NPORTS-1:0]        s_we_o,
  output logic [NPORTS-1:0][3:0]   s_be_o,
  output logic [NPORTS-1:0][31:0]  s_addr_o,
  output logic [NPORTS-1:0][31:0]  s_wdata_o,
  input  logic [NPORTS-1:0]        s_gnt_i,
  input  logic [NPORTS-1:0]        s_rvalid_i,
  input  logic [NPORTS-1:0][31:0]  s_rdata_i
);

  // Port index width leaves room for index NPORTS (the error responder).
  localparam int unsigned PW = $clog2(NPORTS + 1);
  localparam int unsigned AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(MAX_OUTSTANDING - 1);

`ifdef EXT_PERIPH_DEMUX_ERR_RESP_EN
  localparam logic [PW-1:0] ERR_PORT = PW'(NPORTS);
  logic r_err_pend;
`endif

  logic [PW-1:0] r_fifo [0:MAX_OUTSTANDING-1];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_last;      // port of the youngest entry, valid while r_count != 0

  logic          w_hit;
  logic [PW-1:0] w_sel;
  logic [PW-1:0] w_head;
  logic          w_head_vld;
  logic [31:0]   w_head_dat;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_cnt_after;
  logic          w_admit;
  logic          w_sel_gnt;

  function automatic logic [AW-1:0] f_next(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Address decode: iterate downwards so the lowest matching rule wins.
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (m_addr_i >= ADDR_RULES[i].start_addr && m_addr_i < ADDR_RULES[i].end_addr) begin
        w_hit = 1'b1;
        w_sel = PW'(i);
      end
    end
`ifdef EXT_PERIPH_DEMUX_ERR_RESP_EN
    if (!w_hit) w_sel = ERR_PORT;
`else
    if (!w_hit) w_sel = '0;   // unmapped traffic falls through to port 0
`endif
  end

  // Response path: only the port at the FIFO head may complete a transaction.
  assign w_head = r_fifo[r_rd_ptr];

  always_comb begin
    w_head_vld = 1'b0;
    w_head_dat = '0;
    if (r_count != '0) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (w_head == PW'(i)) begin
          w_head_vld = s_rvalid_i[i];
          w_head_dat = s_rdata_i[i];
        end
      end
`ifdef EXT_PERIPH_DEMUX_ERR_RESP_EN
      if (w_head == ERR_PORT) begin
        w_head_vld = r_err_pend;
        w_head_dat = 32'hBADA_CCE5;
      end
`endif
    end
  end

  assign w_pop      = w_head_vld;
  assign m_rvalid_o = w_head_vld;
  assign m_rdata_o  = w_head_vld ? w_head_dat : 32'h0;

  // Admission looks at the occupancy after this cycle's pop, so a slot freed by
  // a response can be reused in the same cycle (full FIFO with pop included).
  assign w_cnt_after = r_count - CW'(w_pop);
  assign w_admit     = m_req_i
                    && (w_cnt_after < CW'(MAX_OUTSTANDING))
                    && ((w_cnt_after == '0) || (w_sel == r_last));

  always_comb begin
    w_sel_gnt = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (w_sel == PW'(i)) w_sel_gnt = s_gnt_i[i];
    end
`ifdef EXT_PERIPH_DEMUX_ERR_RESP_EN
    if (w_sel == ERR_PORT) w_sel_gnt = 1'b1;
`endif
  end

  assign m_gnt_o = w_admit && w_sel_gnt;
  assign w_push  = m_gnt_o;

  // Request fan-out; the broadcast copies are zeroed while no request is presented.
  always_comb begin
    s_req_o   = '0;
    s_we_o    = '0;
    s_be_o    = '0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    for (int i = 0; i < NPORTS; i++) begin
      s_req_o[i] = w_admit && (w_sel == PW'(i));
      if (m_req_i) begin
        s_we_o[i]    = m_we_i;
        s_be_o[i]    = m_be_i;
        s_addr_o[i]  = m_addr_i;
        s_wdata_o[i] = m_wdata_i;
      end
    end
  end

  // FIFO state. Entry storage and r_last need no reset: both are only read while
  // r_count is non-zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_sel;
        r_last           <= w_sel;
        r_wr_ptr         <= f_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef EXT_PERIPH_DEMUX_ERR_RESP_EN
  // The error responder answers every grant exactly one cycle later. Ordering
  // guarantees its entry is at the head by then.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err_pend <= 1'b0;
    end else begin
      r_err_pend <= w_push && (w_sel == ERR_PORT);
    end
  end
`endif

endmodule

// File: tb/tb_ext_periph_obi_demux.sv
module tb_ext_periph_obi_demux;
  import ext_periph_obi_demux_pkg::*;

  localparam int NP    = 5;
  localparam int MAXO  = 2;
  localparam int NCYC  = 4000;
  localparam logic [31:0] ST = EXT_PERIPHERAL_START_ADDRESS;
`ifdef EXT_PERIPH_DEMUX_ERR_RESP_EN
  localparam int UNMAPPED = NP;
`else
  localparam int UNMAPPED = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  m_req, m_we;
  logic [3:0]            m_be;
  logic [31:0]           m_addr, m_wdata;
  logic                  m_gnt, m_rvalid;
  logic [31:0]           m_rdata;
  logic [NP-1:0]         s_req, s_we;
  logic [NP-1:0][3:0]    s_be;
  logic [NP-1:0][31:0]   s_addr, s_wdata;
  logic [NP-1:0]         s_gnt, s_rvalid;
  logic [NP-1:0][31:0]   s_rdata;

  ext_periph_obi_demux #(.NPORTS(NP), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata)
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: outstanding transactions in grant order, plus per-slave pending replies.
  typedef struct {
    int          port;
    int          gcyc;
    logic [31:0] data;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] pend [NP][$];
  logic [NP-1:0] real_dlv;
  bit          last_gnt;
  int          cyc_cnt;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  // Address map: five 4 KiB windows from the external-peripheral base.
  function automatic int model_sel(input logic [31:0] a);
    logic [31:0] off;
    off = a - ST;
    if (a >= ST && off < 32'(NP) * 32'h1000) return int'(off >> 12);
    return UNMAPPED;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    m_req = 0; m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0;
    s_rvalid = '0; s_rdata = '0;
  endtask

  task automatic req(input logic [31:0] a);
    m_req = 1; m_addr = a; m_we = 0; m_be = 4'hF; m_wdata = '0;
  endtask

  // One cycle of the reference model: compute expected outputs from the
  // sampled inputs, compare, then advance the model by the cycle's handshakes.
  task automatic model_step();
    int n, sel, rm, k;
    bit exp_rv, adm, exp_gnt;
    logic [31:0] exp_rdata;
    logic [NP-1:0] exp_sreq;
    ent_t e;
    n = mq.size();
    exp_rv = 0;
    exp_rdata = '0;
    if (n > 0) begin
      if (mq[0].port == NP) exp_rv = (cyc_cnt == mq[0].gcyc + 1);
      else                  exp_rv = s_rvalid[mq[0].port];
      if (exp_rv) exp_rdata = mq[0].data;
    end
    sel = model_sel(m_addr);
    rm  = n - int'(exp_rv);
    adm = m_req && (rm < MAXO) && (rm == 0 || sel == mq[n-1].port);
    exp_sreq = '0;
    exp_gnt  = 0;
    if (adm) begin
      if (sel < NP) begin
        exp_sreq[sel] = 1'b1;
        exp_gnt = s_gnt[sel];
      end else begin
        exp_gnt = 1;
      end
    end
    if (rst_n) begin
      chk1("rnd_gnt", m_gnt, exp_gnt);
      chk1("rnd_rvalid", m_rvalid, exp_rv);
      chk32("rnd_rdata", m_rdata, exp_rdata);
      chk32("rnd_sreq", 32'(s_req), 32'(exp_sreq));
      if (m_req) begin
        k = cyc_cnt % NP;
        chk32("rnd_bcast_addr", s_addr[k], m_addr);
        chk32("rnd_bcast_wdata", s_wdata[k], m_wdata);
        chk32("rnd_bcast_be", 32'(s_be[k]), 32'(m_be));
        chk1("rnd_bcast_we", s_we[k], m_we);
      end
    end
    if (exp_rv) e = mq.pop_front();
    for (int p = 0; p < NP; p++) begin
      if (s_rvalid[p] && real_dlv[p] && pend[p].size() > 0) void'(pend[p].pop_front());
    end
    if (exp_gnt) begin
      e.port = sel;
      e.gcyc = cyc_cnt;
      e.data = (sel == NP) ? 32'hBADACCE5 : $urandom;
      mq.push_back(e);
      if (sel < NP) pend[sel].push_back(e.data);
    end
    last_gnt = exp_gnt;
    if (!rst_n) begin
      mq.delete();
      for (int p = 0; p < NP; p++) pend[p].delete();
      last_gnt = 1;
    end
    cyc_cnt++;
  endtask

  task automatic drive_random(input bit quiet);
    int r;
    rst_n = quiet ? 1'b1 : ($urandom_range(0, 699) != 0);
    if (!m_req || last_gnt) begin
      if (!quiet && $urandom_range(0, 9) < 7) begin
        r = $urandom_range(0, NP);
        m_req = 1; m_we = 1'($urandom); m_be = 4'($urandom); m_wdata = $urandom;
        if (r < NP)
          m_addr = ST + 32'(r) * 32'h1000 + (32'($urandom_range(0, 1023)) << 2);
        else if ($urandom_range(0, 1) == 0)
          m_addr = ST + 32'h8000 + (32'($urandom_range(0, 255)) << 2);
        else
          m_addr = 32'h1000_0000 + (32'($urandom_range(0, 255)) << 2);
      end else begin
        m_req = 0; m_addr = $urandom; m_wdata = $urandom;
      end
    end
    for (int p = 0; p < NP; p++) begin
      s_gnt[p] = ($urandom_range(0, 3) != 0);
      if (pend[p].size() > 0) begin
        real_dlv[p] = ($urandom_range(0, 2) == 0);
        s_rvalid[p] = real_dlv[p];
        s_rdata[p]  = real_dlv[p] ? pend[p][0] : $urandom;
      end else begin
        real_dlv[p] = 0;
        s_rvalid[p] = ($urandom_range(0, 24) == 0);   // stray response, must be ignored
        s_rdata[p]  = $urandom;
      end
    end
  endtask

  initial begin
    rst_n = 0; idle_in(); s_gnt = '1; real_dlv = '0; last_gnt = 0; cyc_cnt = 0;

    // Pin the address-map model.
    chk32("map_p0", 32'(model_sel(ST)), 32'd0);
    chk32("map_p1", 32'(model_sel(ST + 32'h1004)), 32'd1);
    chk32("map_p4_top", 32'(model_sel(ST + 32'h4FFC)), 32'd4);
    chk32("map_unmapped", 32'(model_sel(ST + 32'h8000)), 32'(UNMAPPED));

    step(); step();
    rst_n = 1;
    #1;
    chk1("rst_gnt", m_gnt, 0);
    chk1("rst_rvalid", m_rvalid, 0);
    chk32("rst_rdata", m_rdata, 0);
    chk32("rst_sreq", 32'(s_req), 0);
    chk32("rst_saddr", s_addr[0], 0);

    // Routing to port 1.
    step(); req(ST + 32'h1004); #1;
    chk32("route_sreq", 32'(s_req), 32'b00010);
    chk1("route_gnt", m_gnt, 1);
    step(); m_req = 0; s_rvalid[1] = 1; s_rdata[1] = 32'h12345678; #1;
    chk1("route_rvalid", m_rvalid, 1);
    chk32("route_rdata", m_rdata, 32'h12345678);
    step(); s_rvalid = '0; req(ST + 32'h2000); #1;
    chk1("route_rvalid_off", m_rvalid, 0);
    chk32("route_rdata_zero", m_rdata, 0);
    chk32("route_empty_sreq", 32'(s_req), 32'b00100);
    chk1("route_empty_gnt", m_gnt, 1);
    step(); m_req = 0; s_rvalid[2] = 1; s_rdata[2] = 32'hCAFE0002; #1;
    chk32("route2_rdata", m_rdata, 32'hCAFE0002);

    // Back-to-back to port 3 with responses withheld.
    step(); s_rvalid = '0; req(ST + 32'h3000); #1;
    chk1("b2b_gnt1", m_gnt, 1);
    step(); req(ST + 32'h3004); #1;
    chk1("b2b_gnt2", m_gnt, 1);
    step(); req(ST + 32'h3008); #1;
    chk1("b2b_stall", m_gnt, 0);
    chk32("b2b_stall_sreq", 32'(s_req), 0);
    step(); #1;
    chk1("b2b_stall2", m_gnt, 0);
    step(); s_rvalid[3] = 1; s_rdata[3] = 32'h33330001; #1;
    chk1("b2b_rvalid", m_rvalid, 1);
    chk32("b2b_rdata1", m_rdata, 32'h33330001);
    chk1("b2b_gnt_on_pop", m_gnt, 1);
    chk32("b2b_sreq_on_pop", 32'(s_req), 32'b01000);
    step(); m_req = 0; s_rdata[3] = 32'h33330002; #1;
    chk32("b2b_rdata2", m_rdata, 32'h33330002);
    step(); s_rdata[3] = 32'h33330003; #1;
    chk32("b2b_rdata3", m_rdata, 32'h33330003);

    // Ordering: port 2 waits behind an outstanding port-0 read.
    step(); s_rvalid = '0; req(ST + 32'h0010); #1;
    chk1("ord_gnt0", m_gnt, 1);
    step(); req(ST + 32'h2010); #1;
    chk32("ord_hold_sreq", 32'(s_req), 0);
    chk1("ord_hold_gnt", m_gnt, 0);
    step(); #1;
    chk32("ord_hold_sreq2", 32'(s_req), 0);
    step(); s_rvalid[0] = 1; s_rdata[0] = 32'h00000A0A; #1;
    chk32("ord_rdata0", m_rdata, 32'h00000A0A);
    chk32("ord_release_sreq", 32'(s_req), 32'b00100);
    chk1("ord_release_gnt", m_gnt, 1);
    step(); m_req = 0; s_rvalid = '0; s_rvalid[2] = 1; s_rdata[2] = 32'h22220B0B; #1;
    chk32("ord_rdata2", m_rdata, 32'h22220B0B);

    // Unmapped address.
    step(); s_rvalid = '0; req(ST + 32'h8000); #1;
`ifdef EXT_PERIPH_DEMUX_ERR_RESP_EN
    chk1("unm_gnt", m_gnt, 1);
    chk32("unm_sreq", 32'(s_req), 0);
    step(); m_req = 0; #1;
    chk1("unm_rvalid", m_rvalid, 1);
    chk32("unm_rdata", m_rdata, 32'hBADACCE5);
    step(); #1;
    chk1("unm_rvalid_off", m_rvalid, 0);
`else
    chk32("unm_sreq", 32'(s_req), 32'b00001);
    chk1("unm_gnt", m_gnt, 1);
    step(); m_req = 0; s_rvalid[0] = 1; s_rdata[0] = 32'h00000F0F; #1;
    chk1("unm_rvalid", m_rvalid, 1);
    chk32("unm_rdata", m_rdata, 32'h00000F0F);
    step(); s_rvalid = '0; #1;
    chk1("unm_rvalid_off", m_rvalid, 0);
`endif

    // Stray response while empty, then reset with two outstanding.
    step(); s_rvalid[4] = 1; s_rdata[4] = 32'hDEADBEEF; #1;
    chk1("stray_rvalid", m_rvalid, 0);
    chk32("stray_rdata", m_rdata, 0);
    step(); s_rvalid = '0; req(ST + 32'h1000); #1;
    chk1("rstmid_gnt1", m_gnt, 1);
    step(); req(ST + 32'h1004); #1;
    chk1("rstmid_gnt2", m_gnt, 1);
    step(); m_req = 0; rst_n = 0;
    step(); rst_n = 1; s_rvalid[1] = 1; s_rdata[1] = 32'h11111111; #1;
    chk1("late_rvalid", m_rvalid, 0);
    chk32("late_rdata", m_rdata, 0);
    step(); s_rvalid = '0; req(ST + 32'h4000); #1;
    chk32("post_rst_sreq", 32'(s_req), 32'b10000);
    chk1("post_rst_gnt", m_gnt, 1);
    step(); m_req = 0; s_rvalid[4] = 1; s_rdata[4] = 32'h44444444; #1;
    chk1("post_rst_rvalid", m_rvalid, 1);
    chk32("post_rst_rdata", m_rdata, 32'h44444444);

    // Randomized phase against the model, starting from a fresh reset.
    step(); idle_in(); rst_n = 0;
    @(negedge clk); model_step();
    for (int c = 0; c < NCYC; c++) begin
      step();
      drive_random(c >= NCYC - 80);
      @(negedge clk);
      model_step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
